ysyx_22050019_axi_arbiter: RTL and testbench
============================================

YSYX_22050019_AXI_ARBITER -- requirements
Module: ysyx_22050019_axi_arbiter

Interface
REQ-001 Parameter AXI_DATA_WIDTH, default 64, data bus width for all ports.
REQ-002 Parameter AXI_ADDR_WIDTH, default 32, address bus width for all ports.
REQ-003 clk  in  1  clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 m0_ar_{valid,addr,prot,len,size,burst}  in  1/AW/3/8/3/2  IFU read-address request; m0_ar_ready  out  1.
REQ-006 m0_r_{valid,resp,data,last}  out  1/2/DW/1  IFU read data; m0_r_ready  in  1.
REQ-007 m1_ar_* / m1_r_*  same widths as m0  LSU read-address and read-data channels.
REQ-008 m1_aw_{valid,addr,prot,len,size,burst}  in  1/AW/3/8/3/2  LSU write address; m1_aw_ready  out  1.
REQ-009 m1_w_{valid,data,strb,last}  in  1/DW/DW/8/1  LSU write data; m1_w_ready  out  1.
REQ-010 m1_b_{valid,resp}  out  1/2  LSU write response; m1_b_ready  in  1.
REQ-011 s_ar_*, s_r_*, s_aw_*, s_w_*, s_b_*  mirrored directions  single AXI master port to the SRAM slave.

Function
REQ-012 Read FSM states: R_IDLE, R_M0 (IFU granted), R_M1 (LSU granted); shall be registered.
REQ-013 R_IDLE: m1_ar_valid and not wr_busy -> R_M1; else m0_ar_valid -> R_M0; else stay; LSU has fixed priority.
REQ-014 Grant takes effect the cycle after the request is seen; no AR forwarded to slave in R_IDLE.
REQ-015 In R_Mx, s_ar_* driven from master x, combinationally; s_ar_valid = mx_ar_valid & ~ar_done.
REQ-016 mx_ar_ready = s_ar_ready & ~ar_done in R_Mx; 0 for the other master and in R_IDLE.
REQ-017 ar_done set on s_ar handshake; cleared on return to R_IDLE; exactly one AR per grant.
REQ-018 In R_Mx, s_r_* routed to master x, s_r_ready = mx_r_ready; other master's r_valid = 0.
REQ-019 R_Mx -> R_IDLE on s_r_valid & s_r_ready & s_r_last; bursts (len up to 255) never interleave.
REQ-020 Write path: m1_aw/w/b passed combinationally to s_aw/w/b, gated by write grant rules below.
REQ-021 wr_busy set on s_aw handshake, cleared on s_b handshake; simultaneous set and clear -> set wins.
REQ-022 m1_aw_ready and s_aw_valid forced 0 while wr_busy (one outstanding write) or state is R_M1.
REQ-023 LSU read not granted while wr_busy or m1_aw_valid is high (write-before-read ordering); IFU unaffected.
REQ-024 s_r_valid in R_IDLE is dropped (s_r_ready = 0); unexpected s_b_valid with wr_busy = 0 shall be forwarded unchanged.
REQ-025 No combinational path from s_*_ready to s_*_valid other than through ar_done and wr_busy registers.

Reset
REQ-026 rst -> state R_IDLE, ar_done 0, wr_busy 0 on the next edge, overriding any handshake in progress.
REQ-027 During and after reset: all s_*_valid, mx_*_ready, mx_r_valid, m1_b_valid = 0 until a new grant.
REQ-028 Reset mid-burst abandons the burst; slave is reset by the same rst.

Structure
REQ-029 Shared package holds read-state encoding (2 bits), AXI resp constants (OKAY=0) and width defaults.
REQ-030 Single module; no sub-module; read mux and write gating in one file.

Verification
REQ-031 m0_ar_valid, addr 0x8000_0000, len 0 -> one s_ar handshake, m0 receives one beat with r_last 1, FSM R_M0 -> R_IDLE.
REQ-032 m0 and m1 ar_valid same cycle -> R_M1 granted first; m0 served after m1's last beat; m0_ar_ready 0 meanwhile.
REQ-033 m1 read len 3 at 0x8000_0100 -> four beats to m1 in order, m0_r_valid stays 0 throughout.
REQ-034 m1 write 0x8000_0008 data 0x1122334455667788 strb 0xFF, then m1 read same addr -> read granted only after b handshake, returns written data.
REQ-035 m0_ar_valid held high after its burst ends -> second AR issued only after re-grant, never two ARs per grant.
REQ-036 rst asserted during m0 4-beat burst after beat 2 -> all valids 0 next cycle, FSM R_IDLE, wr_busy 0.

Source files
------------

// File: rtl/ysyx_22050019_axi_arbiter_pkg.sv
// Shared definitions for the IFU/LSU to SRAM AXI arbiter: read-grant state
// encoding, AXI response codes and default bus widths.
package ysyx_22050019_axi_arbiter_pkg;

   localparam int DEF_DATA_WIDTH = 64;
   localparam int DEF_ADDR_WIDTH = 32;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Which master currently owns the shared read channel.
   typedef enum logic [1:0] {
      R_IDLE = 2'b00,
      R_M0   = 2'b01,
      R_M1   = 2'b10
   } rd_state_e;

endpackage

// File: rtl/ysyx_22050019_axi_arbiter.sv
// Two-master AXI arbiter: IFU (m0, read only) and LSU (m1, read/write) share
// one AXI master port towards the SRAM slave. Reads are granted a whole burst
// at a time with the LSU taking priority; the LSU write path is a gated
// pass-through allowing a single outstanding write, and an LSU read is held
// off until any pending or announced write has completed.
module ysyx_22050019_axi_arbiter
   import ysyx_22050019_axi_arbiter_pkg::*;
#(
   parameter int AXI_DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int AXI_ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   // IFU read
   input  logic                          m0_ar_valid,
   input  logic [AXI_ADDR_WIDTH-1:0]     m0_ar_addr,
   input  logic [2:0]                    m0_ar_prot,
   input  logic [7:0]                    m0_ar_len,
   input  logic [2:0]                    m0_ar_size,
   input  logic [1:0]                    m0_ar_burst,
   output logic                          m0_ar_ready,
   output logic                          m0_r_valid,
   output logic [1:0]                    m0_r_resp,
   output logic [AXI_DATA_WIDTH-1:0]     m0_r_data,
   output logic                          m0_r_last,
   input  logic                          m0_r_ready,
   // LSU read
   input  logic                          m1_ar_valid,
   input  logic [AXI_ADDR_WIDTH-1:0]     m1_ar_addr,
   input  logic [2:0]                    m1_ar_prot,
   input  logic [7:0]                    m1_ar_len,
   input  logic [2:0]                    m1_ar_size,
   input  logic [1:0]                    m1_ar_burst,
   output logic                          m1_ar_ready,
   output logic                          m1_r_valid,
   output logic [1:0]                    m1_r_resp,
   output logic [AXI_DATA_WIDTH-1:0]     m1_r_data,
   output logic                          m1_r_last,
   input  logic                          m1_r_ready,
   // LSU write
   input  logic                          m1_aw_valid,
   input  logic [AXI_ADDR_WIDTH-1:0]     m1_aw_addr,
   input  logic [2:0]                    m1_aw_prot,
   input  logic [7:0]                    m1_aw_len,
   input  logic [2:0]                    m1_aw_size,
   input  logic [1:0]                    m1_aw_burst,
   output logic                          m1_aw_ready,
   input  logic                          m1_w_valid,
   input  logic [AXI_DATA_WIDTH-1:0]     m1_w_data,
   input  logic [AXI_DATA_WIDTH/8-1:0]   m1_w_strb,
   input  logic                          m1_w_last,
   output logic                          m1_w_ready,
   output logic                          m1_b_valid,
   output logic [1:0]                    m1_b_resp,
   input  logic                          m1_b_ready,
   // shared port to the SRAM slave
   output logic                          s_ar_valid,
   output logic [AXI_ADDR_WIDTH-1:0]     s_ar_addr,
   output logic [2:0]                    s_ar_prot,
   output logic [7:0]                    s_ar_len,
   output logic [2:0]                    s_ar_size,
   output logic [1:0]                    s_ar_burst,
   input  logic                          s_ar_ready,
   input  logic                          s_r_valid,
   input  logic [1:0]                    s_r_resp,
   input  logic [AXI_DATA_WIDTH-1:0]     s_r_data,
   input  logic                          s_r_last,
   output logic                          s_r_ready,
   output logic                          s_aw_valid,
   output logic [AXI_ADDR_WIDTH-1:0]     s_aw_addr,
   output logic [2:0]                    s_aw_prot,
   output logic [7:0]                    s_aw_len,
   output logic [2:0]                    s_aw_size,
   output logic [1:0]                    s_aw_burst,
   input  logic                          s_aw_ready,
   output logic                          s_w_valid,
   output logic [AXI_DATA_WIDTH-1:0]     s_w_data,
   output logic [AXI_DATA_WIDTH/8-1:0]   s_w_strb,
   output logic                          s_w_last,
   input  logic                          s_w_ready,
   input  logic                          s_b_valid,
   input  logic [1:0]                    s_b_resp,
   output logic                          s_b_ready
);

   rd_state_e state_q;
   logic      ar_done_q;
   logic      wr_busy_q;

   logic ar_hs;
   logic rd_end;
   logic aw_hs;
   logic b_hs;
   logic aw_go;
   logic w_go;

   assign ar_hs  = s_ar_valid & s_ar_ready;
   assign rd_end = s_r_valid & s_r_ready & s_r_last;
   assign aw_hs  = s_aw_valid & s_aw_ready;
   assign b_hs   = s_b_valid & s_b_ready;

   // Read-grant FSM: LSU wins ties but must wait for any announced or
   // outstanding write; a grant lasts until the last beat is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= R_IDLE;
         ar_done_q <= 1'b0;
      end else begin
         case (state_q)
            R_IDLE: begin
               ar_done_q <= 1'b0;
               if (m1_ar_valid && !wr_busy_q && !m1_aw_valid) begin
                  state_q <= R_M1;
               end else if (m0_ar_valid) begin
                  state_q <= R_M0;
               end
            end
            R_M0, R_M1: begin
               if (rd_end) begin
                  state_q   <= R_IDLE;
                  ar_done_q <= 1'b0;
               end else if (ar_hs) begin
                  ar_done_q <= 1'b1;
               end
            end
            default: begin
               state_q   <= R_IDLE;
               ar_done_q <= 1'b0;
            end
         endcase
      end
   end

   // One outstanding write: busy from AW acceptance until the response
   // handshake; a new AW in the same cycle as a B keeps it busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_busy_q <= 1'b0;
      end else if (aw_hs) begin
         wr_busy_q <= 1'b1;
      end else if (b_hs) begin
         wr_busy_q <= 1'b0;
      end
   end

   // Read channel mux: the granted master sees the slave, the other sees
   // nothing; only one AR is let through per grant.
   always_comb begin
      s_ar_valid  = 1'b0;
      s_ar_addr   = '0;
      s_ar_prot   = '0;
      s_ar_len    = '0;
      s_ar_size   = '0;
      s_ar_burst  = '0;
      m0_ar_ready = 1'b0;
      m1_ar_ready = 1'b0;
      m0_r_valid  = 1'b0;
      m1_r_valid  = 1'b0;
      s_r_ready   = 1'b0;
      m0_r_resp   = s_r_resp;
      m0_r_data   = s_r_data;
      m0_r_last   = s_r_last;
      m1_r_resp   = s_r_resp;
      m1_r_data   = s_r_data;
      m1_r_last   = s_r_last;
      if (!rst) begin
         case (state_q)
            R_M0: begin
               s_ar_valid  = m0_ar_valid & ~ar_done_q;
               s_ar_addr   = m0_ar_addr;
               s_ar_prot   = m0_ar_prot;
               s_ar_len    = m0_ar_len;
               s_ar_size   = m0_ar_size;
               s_ar_burst  = m0_ar_burst;
               m0_ar_ready = s_ar_ready & ~ar_done_q;
               m0_r_valid  = s_r_valid;
               s_r_ready   = m0_r_ready;
            end
            R_M1: begin
               s_ar_valid  = m1_ar_valid & ~ar_done_q;
               s_ar_addr   = m1_ar_addr;
               s_ar_prot   = m1_ar_prot;
               s_ar_len    = m1_ar_len;
               s_ar_size   = m1_ar_size;
               s_ar_burst  = m1_ar_burst;
               m1_ar_ready = s_ar_ready & ~ar_done_q;
               m1_r_valid  = s_r_valid;
               s_r_ready   = m1_r_ready;
            end
            default: ;
         endcase
      end
   end

   // A new write may start only when none is outstanding and the LSU does not
   // own the read channel; W follows its AW, or flows freely once AW is in.
   assign aw_go = m1_aw_valid & ~wr_busy_q & (state_q != R_M1) & ~rst;
   assign w_go  = (wr_busy_q | aw_go) & ~rst;

   assign s_aw_valid  = aw_go;
   assign s_aw_addr   = m1_aw_addr;
   assign s_aw_prot   = m1_aw_prot;
   assign s_aw_len    = m1_aw_len;
   assign s_aw_size   = m1_aw_size;
   assign s_aw_burst  = m1_aw_burst;
   assign m1_aw_ready = s_aw_ready & aw_go;

   assign s_w_valid   = m1_w_valid & w_go;
   assign s_w_data    = m1_w_data;
   assign s_w_strb    = m1_w_strb;
   assign s_w_last    = m1_w_last;
   assign m1_w_ready  = s_w_ready & w_go;

   // Responses are forwarded as-is, even one arriving with no write pending.
   assign m1_b_valid  = s_b_valid & ~rst;
   assign m1_b_resp   = s_b_resp;
   assign s_b_ready   = m1_b_ready & ~rst;

endmodule

// File: tb/tb_ysyx_22050019_axi_arbiter.sv
// Bench for the IFU/LSU AXI arbiter: a behavioural SRAM slave, master
// drivers, and a per-master scoreboard of expected read beats.
module tb_ysyx_22050019_axi_arbiter;
   import ysyx_22050019_axi_arbiter_pkg::*;

   logic clk, rst;
   logic m0_ar_valid, m0_ar_ready, m0_r_valid, m0_r_last, m0_r_ready;
   logic [31:0] m0_ar_addr; logic [2:0] m0_ar_prot, m0_ar_size; logic [7:0] m0_ar_len;
   logic [1:0] m0_ar_burst, m0_r_resp; logic [63:0] m0_r_data;
   logic m1_ar_valid, m1_ar_ready, m1_r_valid, m1_r_last, m1_r_ready;
   logic [31:0] m1_ar_addr; logic [2:0] m1_ar_prot, m1_ar_size; logic [7:0] m1_ar_len;
   logic [1:0] m1_ar_burst, m1_r_resp; logic [63:0] m1_r_data;
   logic m1_aw_valid, m1_aw_ready; logic [31:0] m1_aw_addr; logic [2:0] m1_aw_prot, m1_aw_size;
   logic [7:0] m1_aw_len; logic [1:0] m1_aw_burst;
   logic m1_w_valid, m1_w_last, m1_w_ready; logic [63:0] m1_w_data; logic [7:0] m1_w_strb;
   logic m1_b_valid, m1_b_ready; logic [1:0] m1_b_resp;
   logic s_ar_valid, s_ar_ready; logic [31:0] s_ar_addr; logic [2:0] s_ar_prot, s_ar_size;
   logic [7:0] s_ar_len; logic [1:0] s_ar_burst;
   logic s_r_valid, s_r_last, s_r_ready; logic [1:0] s_r_resp; logic [63:0] s_r_data;
   logic s_aw_valid, s_aw_ready; logic [31:0] s_aw_addr; logic [2:0] s_aw_prot, s_aw_size;
   logic [7:0] s_aw_len; logic [1:0] s_aw_burst;
   logic s_w_valid, s_w_last, s_w_ready; logic [63:0] s_w_data; logic [7:0] s_w_strb;
   logic s_b_valid, s_b_ready; logic [1:0] s_b_resp;

   ysyx_22050019_axi_arbiter #(.AXI_DATA_WIDTH(64), .AXI_ADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .m0_ar_valid(m0_ar_valid), .m0_ar_addr(m0_ar_addr), .m0_ar_prot(m0_ar_prot),
      .m0_ar_len(m0_ar_len), .m0_ar_size(m0_ar_size), .m0_ar_burst(m0_ar_burst),
      .m0_ar_ready(m0_ar_ready), .m0_r_valid(m0_r_valid), .m0_r_resp(m0_r_resp),
      .m0_r_data(m0_r_data), .m0_r_last(m0_r_last), .m0_r_ready(m0_r_ready),
      .m1_ar_valid(m1_ar_valid), .m1_ar_addr(m1_ar_addr), .m1_ar_prot(m1_ar_prot),
      .m1_ar_len(m1_ar_len), .m1_ar_size(m1_ar_size), .m1_ar_burst(m1_ar_burst),
      .m1_ar_ready(m1_ar_ready), .m1_r_valid(m1_r_valid), .m1_r_resp(m1_r_resp),
      .m1_r_data(m1_r_data), .m1_r_last(m1_r_last), .m1_r_ready(m1_r_ready),
      .m1_aw_valid(m1_aw_valid), .m1_aw_addr(m1_aw_addr), .m1_aw_prot(m1_aw_prot),
      .m1_aw_len(m1_aw_len), .m1_aw_size(m1_aw_size), .m1_aw_burst(m1_aw_burst),
      .m1_aw_ready(m1_aw_ready), .m1_w_valid(m1_w_valid), .m1_w_data(m1_w_data),
      .m1_w_strb(m1_w_strb), .m1_w_last(m1_w_last), .m1_w_ready(m1_w_ready),
      .m1_b_valid(m1_b_valid), .m1_b_resp(m1_b_resp), .m1_b_ready(m1_b_ready),
      .s_ar_valid(s_ar_valid), .s_ar_addr(s_ar_addr), .s_ar_prot(s_ar_prot),
      .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst),
      .s_ar_ready(s_ar_ready), .s_r_valid(s_r_valid), .s_r_resp(s_r_resp),
      .s_r_data(s_r_data), .s_r_last(s_r_last), .s_r_ready(s_r_ready),
      .s_aw_valid(s_aw_valid), .s_aw_addr(s_aw_addr), .s_aw_prot(s_aw_prot),
      .s_aw_len(s_aw_len), .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst),
      .s_aw_ready(s_aw_ready), .s_w_valid(s_w_valid), .s_w_data(s_w_data),
      .s_w_strb(s_w_strb), .s_w_last(s_w_last), .s_w_ready(s_w_ready),
      .s_b_valid(s_b_valid), .s_b_resp(s_b_resp), .s_b_ready(s_b_ready)
   );

   typedef struct { logic [63:0] data; logic last; } beat_t;
   typedef struct { logic [31:0] addr; int left; } burst_t;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   beat_t exp0[$], exp1[$];
   logic [63:0] ref_mem [logic [31:0]];
   logic [63:0] sl_mem [logic [31:0]];
   int m0_bc[$], m0_lc[$], m1_lc[$];
   int m0_beats = 0, m1_beats = 0, s_ar_cnt = 0;
   bit m0_rv_seen = 0;

   initial begin clk = 0; forever #5 clk = ~clk; end
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #800000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] init_pat(input logic [31:0] a);
      return {a ^ 32'h5A5A_5A5A, ~a};
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] s);
      logic [63:0] r = old;
      for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   function automatic logic [63:0] ref_rd(input logic [31:0] a);
      logic [31:0] w = a & ~32'h7;
      return ref_mem.exists(w) ? ref_mem[w] : init_pat(w);
   endfunction

   function automatic logic [63:0] sl_rd(input logic [31:0] a);
      logic [31:0] w = a & ~32'h7;
      return sl_mem.exists(w) ? sl_mem[w] : init_pat(w);
   endfunction

   task automatic ref_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
      ref_mem[a & ~32'h7] = merge(ref_rd(a), d, s);
   endtask

   // Handshake-sensitive outputs that must be quiet in reset / right after it.
   function automatic logic [10:0] outs_vec();
      return {s_ar_valid, s_aw_valid, s_w_valid, s_r_ready, m0_ar_ready, m1_ar_ready,
              m1_aw_ready, m1_w_ready, m0_r_valid, m1_r_valid, m1_b_valid};
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // SRAM slave: always accepts AR, queues bursts, one beat per cycle.
   burst_t sl_q[$];
   burst_t sl_b;
   bit sl_ract = 0, sl_awgot = 0, sl_wgot = 0, sl_bpend = 0;
   logic [31:0] sl_raddr, sl_awaddr; int sl_rleft = 0;
   logic [63:0] sl_wdata; logic [7:0] sl_wstrb;
   initial begin
      bit rs, arh, rh, awh, wh, bh;
      logic [31:0] ara, awa; logic [7:0] arl; logic [63:0] wd; logic [7:0] ws;
      s_ar_ready = 1; s_r_valid = 0; s_r_resp = RESP_OKAY; s_r_data = '0; s_r_last = 0;
      s_aw_ready = 1; s_w_ready = 1; s_b_valid = 0; s_b_resp = RESP_OKAY;
      forever begin
         @(negedge clk);
         rs = rst; arh = s_ar_valid & s_ar_ready; ara = s_ar_addr; arl = s_ar_len;
         rh = s_r_valid & s_r_ready; awh = s_aw_valid & s_aw_ready; awa = s_aw_addr;
         wh = s_w_valid & s_w_ready; wd = s_w_data; ws = s_w_strb; bh = s_b_valid & s_b_ready;
         @(posedge clk); #1;
         if (rs) begin
            sl_q.delete(); sl_ract = 0; sl_awgot = 0; sl_wgot = 0; sl_bpend = 0;
         end else begin
            if (rh) begin sl_raddr += 8; sl_rleft--; if (sl_rleft == 0) sl_ract = 0; end
            if (arh) sl_q.push_back('{ara, int'(arl) + 1});
            if (!sl_ract && sl_q.size() > 0) begin
               sl_b = sl_q.pop_front(); sl_raddr = sl_b.addr; sl_rleft = sl_b.left; sl_ract = 1;
            end
            if (bh) sl_bpend = 0;
            if (awh) begin sl_awgot = 1; sl_awaddr = awa; end
            if (wh) begin sl_wgot = 1; sl_wdata = wd; sl_wstrb = ws; end
            if (sl_awgot && sl_wgot && !sl_bpend) begin
               sl_mem[sl_awaddr & ~32'h7] = merge(sl_rd(sl_awaddr), sl_wdata, sl_wstrb);
               sl_bpend = 1; sl_awgot = 0; sl_wgot = 0;
            end
         end
         s_r_valid = sl_ract; s_r_data = sl_rd(sl_raddr); s_r_last = (sl_rleft == 1);
         s_aw_ready = !sl_awgot; s_w_ready = !sl_wgot; s_b_valid = sl_bpend;
      end
   end

   // LSU read-data backpressure.
   initial begin
      m1_r_ready = 1;
      forever begin @(posedge clk); #1; m1_r_ready = ($urandom_range(0, 3) != 0); end
   end

   // Read-beat monitor: pops the scoreboard on every accepted beat.
   beat_t mon_e;
   initial begin
      forever begin
         @(negedge clk);
         if (s_ar_valid & s_ar_ready) s_ar_cnt++;
         if (m0_r_valid) m0_rv_seen = 1;
         if (m0_r_valid & m0_r_ready) begin
            m0_beats++; m0_bc.push_back(cyc + 1);
            if (m0_r_last) m0_lc.push_back(cyc + 1);
            if (exp0.size() == 0) check_eq("m0_r_unexpected", 1, 0);
            else begin
               mon_e = exp0.pop_front();
               check_eq("m0_r_data", m0_r_data, mon_e.data);
               check_eq("m0_r_last", {63'd0, m0_r_last}, {63'd0, mon_e.last});
            end
         end
         if (m1_r_valid & m1_r_ready) begin
            m1_beats++;
            if (m1_r_last) m1_lc.push_back(cyc + 1);
            if (exp1.size() == 0) check_eq("m1_r_unexpected", 1, 0);
            else begin
               mon_e = exp1.pop_front();
               check_eq("m1_r_data", m1_r_data, mon_e.data);
               check_eq("m1_r_last", {63'd0, m1_r_last}, {63'd0, mon_e.last});
            end
         end
      end
   end

   task automatic push_burst(input int m, input logic [31:0] a, input logic [7:0] len);
      beat_t b;
      for (int i = 0; i <= int'(len); i++) begin
         b.data = ref_rd(a + 32'(8 * i)); b.last = (i == int'(len));
         if (m == 0) exp0.push_back(b); else exp1.push_back(b);
      end
   endtask

   task automatic rd_req(input int m, input logic [31:0] a, input logic [7:0] len, output int hs_cyc);
      int n = 0; bit hs = 0;
      push_burst(m, a, len);
      if (m == 0) begin m0_ar_valid = 1; m0_ar_addr = a; m0_ar_len = len; end
      else begin m1_ar_valid = 1; m1_ar_addr = a; m1_ar_len = len; end
      while (!hs && n < 300) begin
         @(negedge clk);
         hs = (m == 0) ? (m0_ar_valid & m0_ar_ready) : (m1_ar_valid & m1_ar_ready);
         tick(); n++;
      end
      if (m == 0) m0_ar_valid = 0; else m1_ar_valid = 0;
      hs_cyc = cyc;
      if (!hs) check_eq("rd_ar_timeout", 0, 1);
      $display("[%0d] rd m%0d addr=%h len=%0d ar_hs=%0d", cyc, m, a, len, hs);
   endtask

   task automatic wr_req(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                         input bit wait_b, output int b_cyc);
      int n = 0; bit ad = 0, wd = 0, ah, wh, bh = 0;
      m1_aw_valid = 1; m1_aw_addr = a; m1_w_valid = 1; m1_w_data = d; m1_w_strb = s; m1_w_last = 1;
      while (!(ad && wd) && n < 300) begin
         @(negedge clk);
         ah = m1_aw_valid & m1_aw_ready; wh = m1_w_valid & m1_w_ready;
         tick(); n++;
         if (ah) begin ad = 1; m1_aw_valid = 0; end
         if (wh) begin wd = 1; m1_w_valid = 0; end
      end
      m1_aw_valid = 0; m1_w_valid = 0;
      if (!(ad && wd)) check_eq("wr_aw_w_timeout", 0, 1);
      n = 0;
      while (wait_b && !bh && n < 300) begin
         @(negedge clk);
         if (m1_b_valid & m1_b_ready) begin bh = 1; check_eq("wr_b_resp", 64'(m1_b_resp), 64'(RESP_OKAY)); end
         tick(); n++;
      end
      b_cyc = cyc;
      if (wait_b && !bh) check_eq("wr_b_timeout", 0, 1);
      $display("[%0d] wr addr=%h data=%h strb=%h", cyc, a, d, s);
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while (n < 600) begin
         @(negedge clk);
         if (exp0.size() == 0 && exp1.size() == 0) break;
         n++;
      end
      if (n >= 600) check_eq(tag, 64'(exp0.size() + exp1.size()), 0);
      tick();
   endtask

   initial begin
      int h0, h1, bc, base, n, hs_n, first_last;
      int hs_c[2];
      logic [31:0] a0, a1, wa; logic [7:0] l0, l1, ws; logic [63:0] wdat;
      rst = 1; m0_r_ready = 1; m1_b_ready = 1;
      m0_ar_valid = 1; m0_ar_addr = 32'h8000_0000; m0_ar_prot = 0; m0_ar_len = 0; m0_ar_size = 3; m0_ar_burst = 1;
      m1_ar_valid = 1; m1_ar_addr = 32'h8000_0000; m1_ar_prot = 0; m1_ar_len = 0; m1_ar_size = 3; m1_ar_burst = 1;
      m1_aw_valid = 1; m1_aw_addr = 32'h8000_0000; m1_aw_prot = 0; m1_aw_len = 0; m1_aw_size = 3; m1_aw_burst = 1;
      m1_w_valid = 1; m1_w_data = '0; m1_w_strb = 8'hFF; m1_w_last = 1;
      // reset with every master request raised
      repeat (3) tick();
      @(negedge clk);
      check_eq("rst_outputs", 64'(outs_vec()), 0);
      check_eq("rst_s_b_ready", 64'(s_b_ready), 0);
      tick();
      m0_ar_valid = 0; m1_ar_valid = 0; m1_aw_valid = 0; m1_w_valid = 0;
      tick();
      rst = 0;
      @(negedge clk);
      check_eq("post_rst_outputs", 64'(outs_vec()), 0);
      check_eq("post_rst_state", 64'(dut.state_q), 64'(R_IDLE));
      check_eq("post_rst_wr_busy", 64'(dut.wr_busy_q), 0);
      tick();

      // single-beat IFU read
      base = s_ar_cnt; m0_lc.delete();
      rd_req(0, 32'h8000_0000, 8'd0, h0);
      wait_drain("t1_drain");
      check_eq("t1_ar_count", 64'(s_ar_cnt - base), 1);
      check_eq("t1_last_count", 64'(m0_lc.size()), 1);
      check_eq("t1_state_idle", 64'(dut.state_q), 64'(R_IDLE));

      // LSU 4-beat burst, IFU silent
      m0_rv_seen = 0; base = m1_beats;
      rd_req(1, 32'h8000_0100, 8'd3, h1);
      wait_drain("t3_drain");
      check_eq("t3_m1_beats", 64'(m1_beats - base), 4);
      check_eq("t3_m0_r_valid_seen", 64'(m0_rv_seen), 0);

      // simultaneous requests: LSU first, IFU after LSU's last beat
      m0_bc.delete(); m1_lc.delete();
      fork
         rd_req(0, 32'h8000_0080, 8'd1, h0);
         rd_req(1, 32'h8000_00C0, 8'd2, h1);
      join
      wait_drain("t2_drain");
      check_eq("t2_m1_before_m0", 64'(h1 < h0), 1);
      first_last = (m1_lc.size() > 0) ? m1_lc[0] : 32'h7FFF_FFFF;
      check_eq("t2_m0_after_m1_last", 64'((m0_bc.size() > 0) && (m0_bc[0] > first_last)), 1);

      // write then read of the same address from the LSU
      ref_write(32'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF);
      fork
         wr_req(32'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 1'b1, bc);
         rd_req(1, 32'h8000_0008, 8'd0, h1);
      join
      wait_drain("t4_drain");
      check_eq("t4_read_after_b", 64'(h1 > bc), 1);

      // IFU holds ar_valid across two bursts: second AR only after re-grant
      m0_lc.delete(); hs_n = 0; n = 0;
      push_burst(0, 32'h8000_0200, 8'd1);
      push_burst(0, 32'h8000_0200, 8'd1);
      m0_ar_valid = 1; m0_ar_addr = 32'h8000_0200; m0_ar_len = 8'd1;
      while (hs_n < 2 && n < 300) begin
         @(negedge clk);
         if (m0_ar_valid & m0_ar_ready) begin hs_c[hs_n] = cyc + 1; hs_n++; end
         tick(); n++;
      end
      m0_ar_valid = 0;
      wait_drain("t5_drain");
      check_eq("t5_ar_handshakes", 64'(hs_n), 2);
      first_last = (m0_lc.size() > 0) ? m0_lc[0] : 32'h7FFF_FFFF;
      check_eq("t5_second_ar_after_last", 64'((hs_n == 2) && (hs_c[1] > first_last)), 1);

      // mixed traffic
      for (int it = 0; it < 6; it++) begin
         a0 = 32'h8000_0200 + 32'(64 * $urandom_range(0, 7)); l0 = 8'($urandom_range(0, 3));
         a1 = 32'h8000_0400 + 32'(64 * $urandom_range(0, 7)); l1 = 8'($urandom_range(0, 3));
         wa = 32'h8000_1000 + 32'(8 * $urandom_range(0, 15));
         wdat = {$urandom, $urandom}; ws = 8'($urandom_range(1, 255));
         ref_write(wa, wdat, ws);
         fork
            rd_req(0, a0, l0, h0);
            rd_req(1, a1, l1, h1);
            wr_req(wa, wdat, ws, 1'b1, bc);
         join
         wait_drain("mix_drain");
      end
      rd_req(1, wa, 8'd0, h1);
      wait_drain("mix_readback_drain");

      // reset during an IFU burst with a write response still pending
      m1_b_ready = 0;
      ref_write(32'h8000_0040, 64'hDEAD_BEEF_0BAD_F00D, 8'h0F);
      wr_req(32'h8000_0040, 64'hDEAD_BEEF_0BAD_F00D, 8'h0F, 1'b0, bc);
      @(negedge clk);
      check_eq("t6_wr_busy_before", 64'(dut.wr_busy_q), 1);
      tick();
      base = m0_beats;
      rd_req(0, 32'h8000_0300, 8'd3, h0);
      for (int i = 0; i < 300; i++) begin
         if (m0_beats >= base + 2) break;
         tick();
      end
      check_eq("t6_two_beats_before_rst", 64'(m0_beats - base), 2);
      rst = 1;
      tick();
      rst = 0;
      check_eq("t6_abandoned_beats", 64'(exp0.size()), 2);
      exp0.delete();
      @(negedge clk);
      check_eq("t6_outputs_after_rst", 64'(outs_vec()), 0);
      check_eq("t6_state_after_rst", 64'(dut.state_q), 64'(R_IDLE));
      check_eq("t6_wr_busy_after_rst", 64'(dut.wr_busy_q), 0);
      tick();
      m1_b_ready = 1;
      rd_req(0, 32'h8000_0040, 8'd0, h0);
      wait_drain("t6_recover_drain");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
